// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared FIFO constants and width helper
package fifo_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_DEPTH      = 16;

  // Smallest n with 2**n >= value; usable in constant expressions.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// rtl/fifo_ram.sv - FIFO storage, one sync write port, one async read port
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = DEFAULT_DEPTH,
  parameter int AW         = clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_buffer.sv
// rtl/fifo_buffer.sv - first-word-fall-through FIFO with sticky overflow/underflow flags
module fifo_buffer
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = DEFAULT_DEPTH,
  parameter int AF_LEVEL   = DEPTH - 2
) (
  input  logic                    ap_clk,
  input  logic                    ap_rst_n,
  input  logic [DATA_WIDTH-1:0]   fifo_i_din,
  output logic                    fifo_i_full_n,
  input  logic                    fifo_i_write,
  output logic [DATA_WIDTH-1:0]   fifo_o_dout,
  output logic                    fifo_o_empty_n,
  input  logic                    fifo_o_read,
  input  logic                    fifo_clr,
  output logic [clog2(DEPTH):0]   count,
  output logic                    almost_full,
  output logic                    ovf,
  output logic                    udf
);

  localparam int AW = clog2(DEPTH);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        wr_accept;
  logic        rd_accept;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign count          = wr_ptr - rd_ptr;
  assign fifo_i_full_n  = (count != (AW + 1)'(DEPTH));
  assign fifo_o_empty_n = (count != '0);
  assign almost_full    = (int'(count) >= AF_LEVEL);

  assign wr_accept = fifo_i_write && fifo_i_full_n  && !fifo_clr;
  assign rd_accept = fifo_o_read  && fifo_o_empty_n && !fifo_clr;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovf    <= 1'b0;
      udf    <= 1'b0;
    end else if (fifo_clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovf    <= 1'b0;
      udf    <= 1'b0;
    end else begin
      if (wr_accept) wr_ptr <= wr_ptr + 1'b1;
      if (rd_accept) rd_ptr <= rd_ptr + 1'b1;
      if (fifo_i_write && !fifo_i_full_n)  ovf <= 1'b1;
      if (fifo_o_read  && !fifo_o_empty_n) udf <= 1'b1;
    end
  end

  fifo_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH),
    .AW        (AW)
  ) u_ram (
    .clk  (ap_clk),
    .we   (wr_accept),
    .waddr(wr_ptr[AW-1:0]),
    .wdata(fifo_i_din),
    .raddr(rd_ptr[AW-1:0]),
    .rdata(fifo_o_dout)
  );

endmodule

// File: tb/tb_fifo_buffer.sv
// tb/tb_fifo_buffer.sv - self-checking bench for fifo_buffer, DEPTH=4 AF_LEVEL=3
module tb_fifo_buffer;

  localparam int DW = 8;
  localparam int DEPTH = 4;
  localparam int AF = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] fifo_i_din;
  logic          fifo_i_full_n;
  logic          fifo_i_write;
  logic [DW-1:0] fifo_o_dout;
  logic          fifo_o_empty_n;
  logic          fifo_o_read;
  logic          fifo_clr;
  logic [2:0]    count;
  logic          almost_full;
  logic          ovf;
  logic          udf;

  int n_checks = 0;
  int n_pass = 0;

  logic [DW-1:0] mq[$];
  bit m_ovf, m_udf;

  fifo_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_LEVEL(AF)) dut (
    .ap_clk        (clk),
    .ap_rst_n      (rst_n),
    .fifo_i_din    (fifo_i_din),
    .fifo_i_full_n (fifo_i_full_n),
    .fifo_i_write  (fifo_i_write),
    .fifo_o_dout   (fifo_o_dout),
    .fifo_o_empty_n(fifo_o_empty_n),
    .fifo_o_read   (fifo_o_read),
    .fifo_clr      (fifo_clr),
    .count         (count),
    .almost_full   (almost_full),
    .ovf           (ovf),
    .udf           (udf)
  );

  always #5 clk = ~clk;

  // Drive one cycle, advance the queue model by the same rules, sample 1ns after the edge.
  task automatic step(input bit wr, input bit rd, input bit clr, input logic [DW-1:0] d);
    bit full, empty;
    fifo_i_write = wr;
    fifo_o_read  = rd;
    fifo_clr     = clr;
    fifo_i_din   = d;
    @(posedge clk);
    if (clr) begin
      mq.delete();
      m_ovf = 0;
      m_udf = 0;
    end else begin
      full  = (mq.size() == DEPTH);
      empty = (mq.size() == 0);
      if (wr && full)  m_ovf = 1;
      if (rd && empty) m_udf = 1;
      if (rd && !empty) void'(mq.pop_front());
      if (wr && !full) mq.push_back(d);
    end
    #1;
    fifo_i_write = 0;
    fifo_o_read  = 0;
    fifo_clr     = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    n_checks++; if (count !== 3'd0) $display("FAIL reset_count got %0d exp 0", count); else n_pass++;
    n_checks++; if (fifo_i_full_n !== 1'b1) $display("FAIL reset_full_n got %b exp 1", fifo_i_full_n); else n_pass++;
    n_checks++; if (fifo_o_empty_n !== 1'b0) $display("FAIL reset_empty_n got %b exp 0", fifo_o_empty_n); else n_pass++;
    n_checks++; if ({almost_full, ovf, udf} !== 3'b000) $display("FAIL reset_flags got %b exp 000", {almost_full, ovf, udf}); else n_pass++;
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_fill_drain();
    logic [DW-1:0] vals [4];
    vals = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 0, vals[i]);
      n_checks++; if (count !== 3'(i + 1)) $display("FAIL fill_count got %0d exp %0d", count, i + 1); else n_pass++;
      n_checks++; if (almost_full !== (i + 1 >= AF)) $display("FAIL fill_af got %b exp %b", almost_full, (i + 1 >= AF)); else n_pass++;
      n_checks++; if (fifo_i_full_n !== (i != 3)) $display("FAIL fill_full_n got %b exp %b", fifo_i_full_n, (i != 3)); else n_pass++;
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (fifo_o_dout !== vals[i]) $display("FAIL drain_dout got %h exp %h", fifo_o_dout, vals[i]); else n_pass++;
      step(0, 1, 0, 0);
    end
    n_checks++; if (fifo_o_empty_n !== 1'b0) $display("FAIL drain_empty_n got %b exp 0", fifo_o_empty_n); else n_pass++;
  endtask

  task automatic test_full_rw();
    step(0, 0, 1, 0);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 8'(8'hA1 + i));
    n_checks++; if (fifo_o_dout !== 8'hA1) $display("FAIL full_rw_head got %h exp a1", fifo_o_dout); else n_pass++;
    step(1, 1, 0, 8'hFF);
    n_checks++; if (count !== 3'd3) $display("FAIL full_rw_count got %0d exp 3", count); else n_pass++;
    n_checks++; if (ovf !== 1'b1) $display("FAIL full_rw_ovf got %b exp 1", ovf); else n_pass++;
    for (int i = 1; i < 4; i++) begin
      n_checks++; if (fifo_o_dout !== 8'(8'hA1 + i)) $display("FAIL full_rw_dout got %h exp %h", fifo_o_dout, 8'(8'hA1 + i)); else n_pass++;
      step(0, 1, 0, 0);
    end
    n_checks++; if (fifo_o_empty_n !== 1'b0) $display("FAIL full_rw_ff_dropped got empty_n %b exp 0", fifo_o_empty_n); else n_pass++;
    n_checks++; if (ovf !== 1'b1) $display("FAIL ovf_sticky got %b exp 1", ovf); else n_pass++;
  endtask

  task automatic test_empty_rw();
    step(0, 0, 1, 0);
    step(1, 1, 0, 8'h55);
    n_checks++; if (udf !== 1'b1) $display("FAIL empty_rw_udf got %b exp 1", udf); else n_pass++;
    n_checks++; if (fifo_o_empty_n !== 1'b1) $display("FAIL empty_rw_empty_n got %b exp 1", fifo_o_empty_n); else n_pass++;
    n_checks++; if (fifo_o_dout !== 8'h55) $display("FAIL empty_rw_dout got %h exp 55", fifo_o_dout); else n_pass++;
    n_checks++; if (count !== 3'd1) $display("FAIL empty_rw_count got %0d exp 1", count); else n_pass++;
  endtask

  task automatic test_stream();
    step(0, 0, 1, 0);
    step(1, 0, 0, 8'd0);
    for (int i = 1; i < 20; i++) begin
      n_checks++; if (fifo_o_dout !== 8'(i - 1)) $display("FAIL stream_dout got %0d exp %0d", fifo_o_dout, i - 1); else n_pass++;
      step(1, 1, 0, 8'(i));
      n_checks++; if (count !== 3'd1) $display("FAIL stream_count got %0d exp 1", count); else n_pass++;
    end
    n_checks++; if (fifo_o_dout !== 8'd19) $display("FAIL stream_last got %0d exp 19", fifo_o_dout); else n_pass++;
  endtask

  task automatic test_clr();
    step(0, 1, 1, 0);
    step(0, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 8'(i + 8'h30));
    step(1, 0, 1, 8'hEE);
    n_checks++; if (count !== 3'd0) $display("FAIL clr_count got %0d exp 0", count); else n_pass++;
    n_checks++; if ({fifo_o_empty_n, fifo_i_full_n} !== 2'b01) $display("FAIL clr_flags got %b exp 01", {fifo_o_empty_n, fifo_i_full_n}); else n_pass++;
    n_checks++; if ({ovf, udf} !== 2'b00) $display("FAIL clr_sticky got %b exp 00", {ovf, udf}); else n_pass++;
  endtask

  task automatic test_async_reset();
    step(1, 0, 0, 8'h11);
    step(1, 0, 0, 8'h22);
    #4 rst_n = 1'b0;
    #1;
    n_checks++; if (count !== 3'd0) $display("FAIL arst_count got %0d exp 0", count); else n_pass++;
    n_checks++; if ({fifo_o_empty_n, fifo_i_full_n} !== 2'b01) $display("FAIL arst_flags got %b exp 01", {fifo_o_empty_n, fifo_i_full_n}); else n_pass++;
    mq.delete();
    m_ovf = 0;
    m_udf = 0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(1, 0, 0, 8'h77);
    n_checks++; if (fifo_o_dout !== 8'h77 || fifo_o_empty_n !== 1'b1) $display("FAIL arst_write got %h/%b exp 77/1", fifo_o_dout, fifo_o_empty_n); else n_pass++;
  endtask

  task automatic test_random();
    bit wr, rd, clr;
    for (int i = 0; i < 400; i++) begin
      wr  = ($urandom_range(0, 99) < 55);
      rd  = ($urandom_range(0, 99) < 45);
      clr = ($urandom_range(0, 99) < 3);
      step(wr, rd, clr, 8'($urandom));
      n_checks++; if (count !== 3'(mq.size())) $display("FAIL rand_count cyc %0d got %0d exp %0d", i, count, mq.size()); else n_pass++;
      n_checks++; if ({fifo_i_full_n, fifo_o_empty_n, almost_full} !== {mq.size() != DEPTH, mq.size() != 0, mq.size() >= AF})
        $display("FAIL rand_flags cyc %0d got %b exp %b", i, {fifo_i_full_n, fifo_o_empty_n, almost_full}, {mq.size() != DEPTH, mq.size() != 0, mq.size() >= AF});
      else n_pass++;
      n_checks++; if ({ovf, udf} !== {m_ovf, m_udf}) $display("FAIL rand_sticky cyc %0d got %b exp %b", i, {ovf, udf}, {m_ovf, m_udf}); else n_pass++;
      if (mq.size() != 0) begin
        n_checks++; if (fifo_o_dout !== mq[0]) $display("FAIL rand_dout cyc %0d got %h exp %h", i, fifo_o_dout, mq[0]); else n_pass++;
      end
    end
  endtask

  initial begin
    fifo_i_din   = '0;
    fifo_i_write = 1'b0;
    fifo_o_read  = 1'b0;
    fifo_clr     = 1'b0;
    test_reset();
    test_fill_drain();
    test_full_rw();
    test_empty_rw();
    test_stream();
    test_clr();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fifo_buffer.md
FIFO_BUFFER -- requirements
Module: fifo_buffer

Interface
REQ-001 Parameter DATA_WIDTH, default 32, word width in bits.
REQ-002 Parameter DEPTH, default 16, storage words; SHALL be a power of two >= 2.
REQ-003 Parameter AF_LEVEL, default DEPTH-2, occupancy at or above which almost_full asserts.
REQ-004 ap_clk  input  1  sole clock, all state on rising edge.
REQ-005 ap_rst_n  input  1  reset, asynchronous and active-low.
REQ-006 fifo_i_din  input  DATA_WIDTH  write data, sampled with fifo_i_write.
REQ-007 fifo_i_full_n  output  1  high = write side can accept a word.
REQ-008 fifo_i_write  input  1  write strobe, one word per cycle.
REQ-009 fifo_o_dout  output  DATA_WIDTH  head-of-queue word, first-word-fall-through.
REQ-010 fifo_o_empty_n  output  1  high = fifo_o_dout holds a valid word.
REQ-011 fifo_o_read  input  1  read strobe, pops head word.
REQ-012 fifo_clr  input  1  synchronous flush.
REQ-013 count  output  clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-014 almost_full  output  1  high when count >= AF_LEVEL.
REQ-015 ovf  output  1  sticky, set by write attempt while full.
REQ-016 udf  output  1  sticky, set by read attempt while empty.

Function
REQ-017 Write accepted in a cycle iff fifo_i_write && fifo_i_full_n && !fifo_clr; word stored at wr_ptr, wr_ptr increments.
REQ-018 Read accepted iff fifo_o_read && fifo_o_empty_n && !fifo_clr; rd_ptr increments.
REQ-019 Pointers clog2(DEPTH)+1 bits, wrap modulo 2*DEPTH; memory indexed by low clog2(DEPTH) bits; count = wr_ptr - rd_ptr modulo 2*DEPTH.
REQ-020 fifo_i_full_n = (count != DEPTH); fifo_o_empty_n = (count != 0); both derived from registered state only, no combinational path from fifo_i_write or fifo_o_read.
REQ-021 fifo_o_dout = mem[rd_ptr] asynchronously read; value undefined-but-stable when empty_n low.
REQ-022 Latency: word written at cycle N visible on fifo_o_dout with empty_n high at cycle N+1.
REQ-023 Simultaneous accepted read and write: count unchanged, both pointers advance.
REQ-024 Full with simultaneous write and read: read accepted, write rejected, ovf set, count becomes DEPTH-1.
REQ-025 Empty with simultaneous write and read: write accepted, read rejected, udf set, count becomes 1.
REQ-026 fifo_clr high: both pointers zeroed next edge, count 0, ovf/udf cleared, any concurrent write/read dropped; memory contents not cleared.
REQ-027 ovf/udf, once set, hold until fifo_clr or reset.
REQ-028 Read-while-full and write-while-empty behave per REQ-024/025; no other data loss path exists.

Reset
REQ-029 ap_rst_n low asynchronously forces wr_ptr=0, rd_ptr=0, ovf=0, udf=0; hence count=0, fifo_i_full_n=1, fifo_o_empty_n=0, almost_full=(AF_LEVEL==0).
REQ-030 Reset mid-operation discards all queued words; memory array not reset.
REQ-031 Deassertion taken at a rising edge; first write accepted on the first edge after release.

Structure
REQ-032 Shared package fifo_pkg holds the clog2 function and default DEPTH/DATA_WIDTH constants, reused by fifo_switch-adjacent blocks.
REQ-033 Storage in one sub-module fifo_ram: one synchronous write port, one asynchronous read port, no reset, DEPTH x DATA_WIDTH.
REQ-034 fifo_buffer holds pointers, flags, and output logic only.

Verification (DEPTH=4, AF_LEVEL=3)
REQ-035 Write 0xA1,0xA2,0xA3,0xA4 on four consecutive cycles -> count 1,2,3,4; almost_full rises with count=3; full_n low after 4th; reads return A1..A4 in order.
REQ-036 Full FIFO, write 0xFF and read same cycle -> dout A1 popped, 0xFF not stored, ovf=1, count=3.
REQ-037 Empty FIFO, write 0x55 and read same cycle -> udf=1, next cycle empty_n=1, dout=0x55, count=1.
REQ-038 Steady stream 20 words with write and read every cycle after first -> count stays 1, pointers wrap, data order 0..19 intact.
REQ-039 Count=3, assert fifo_clr with write high -> next cycle count=0, empty_n=0, full_n=1, ovf=udf=0.
REQ-040 Count=2, pulse ap_rst_n low mid-cycle -> outputs reset immediately without clock edge; after release, write 0x77 -> dout=0x77 next cycle.
